// File: rtl/shift_sequencer.sv
// Multi-cycle shifter for register-specified amounts: LSL/LSR/ASR/ROR, up to STEP bits per cycle,
// with a valid/ready request side and a held result until the consumer takes it.
module shift_sequencer #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_data,
    input  logic [7:0]       req_amount,
    input  logic [1:0]       req_type,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_carry,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [1:0] TY_LSL = 2'b00;
    localparam logic [1:0] TY_LSR = 2'b01;
    localparam logic [1:0] TY_ASR = 2'b10;
    localparam logic [1:0] TY_ROR = 2'b11;

    // Logical shifts run one step past WIDTH so the carry drains to 0; ASR saturates at all-sign.
    function automatic logic [CNT_W-1:0] eff_amount(input logic [7:0] amt, input logic [1:0] typ);
        int a;
        a = int'(amt);
        case (typ)
            TY_ROR:  a = a % WIDTH;
            TY_ASR:  if (a > WIDTH) a = WIDTH;
            default: if (a > WIDTH + 1) a = WIDTH + 1;
        endcase
        return CNT_W'(a);
    endfunction

    function automatic logic [CNT_W-1:0] step_size(input logic [CNT_W-1:0] rem);
        if (int'(rem) > STEP) return CNT_W'(STEP);
        return rem;
    endfunction

    logic [1:0]              state_q, state_d;
    logic [WIDTH-1:0]        acc_q, acc_d;
    logic                    carry_q, carry_d;
    logic [1:0]              type_q, type_d;
    logic [CNT_W-1:0]        rem_q, rem_d;

    logic                    accept;
    logic [CNT_W-1:0]        eff;
    logic [CNT_W-1:0]        s_amt;
    int                      s_int;
    logic [IDX_W-1:0]        lsl_idx;
    logic [IDX_W-1:0]        rsh_idx;
    logic signed [WIDTH-1:0] acc_s;
    logic [WIDTH-1:0]        sh_res;
    logic                    sh_carry;

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_DONE);
    assign busy       = (state_q == S_SHIFT) || (state_q == S_DONE);
    assign resp_data  = acc_q;
    assign resp_carry = carry_q;
    assign accept     = req_valid & req_ready;

    always_comb begin
        s_amt   = step_size(rem_q);
        s_int   = int'(s_amt);
        lsl_idx = IDX_W'(WIDTH - s_int);
        rsh_idx = IDX_W'(s_int - 1);
        acc_s   = acc_q;
        sh_res  = acc_q;
        sh_carry = 1'b0;
        case (type_q)
            TY_LSL: begin
                sh_res   = acc_q << s_amt;
                sh_carry = acc_q[lsl_idx];
            end
            TY_LSR: begin
                sh_res   = acc_q >> s_amt;
                sh_carry = acc_q[rsh_idx];
            end
            TY_ASR: begin
                sh_res   = acc_s >>> s_amt;
                sh_carry = acc_q[rsh_idx];
            end
            default: begin
                sh_res   = (acc_q >> s_amt) | (acc_q << (WIDTH - s_int));
                sh_carry = acc_q[rsh_idx];
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        type_d  = type_q;
        rem_d   = rem_q;
        eff     = eff_amount(req_amount, req_type);
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    acc_d   = req_data;
                    type_d  = req_type;
                    rem_d   = eff;
                    carry_d = 1'b0;
                    if (eff == '0) begin
                        state_d = S_DONE;
                        // A full-turn rotate still reports bit WIDTH-1 as the rotated-out bit.
                        if (req_type == TY_ROR && req_amount != 8'd0) carry_d = req_data[WIDTH-1];
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                acc_d   = sh_res;
                carry_d = sh_carry;
                rem_d   = rem_q - s_amt;
                if (rem_q == s_amt) state_d = S_DONE;
            end
            S_DONE: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                    acc_d   = '0;
                    carry_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            carry_q <= 1'b0;
            type_q  <= TY_LSL;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            type_q  <= type_d;
            rem_q   <= rem_d;
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer (WIDTH=32, STEP=4) with hand-computed results and latencies.
module tb_shift_sequencer;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_data;
    logic [7:0]  req_amount;
    logic [1:0]  req_type;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_carry;
    logic        busy;

    int total;
    int bad;

    // lat < 0 marks a zero-effective-amount op: result must show up within one cycle.
    typedef struct {
        logic [31:0] d;
        logic [7:0]  a;
        logic [1:0]  t;
        logic [31:0] exp;
        logic        c;
        int          lat;
    } vec_t;

    shift_sequencer #(.WIDTH(32), .STEP(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_amount (req_amount),
        .req_type   (req_type),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_carry (resp_carry),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one op and wait (bounded) for resp_valid; lat counts rising edges after the accept edge.
    task automatic issue(input logic [31:0] d, input logic [7:0] a, input logic [1:0] t,
                         output int lat, output logic [31:0] rd, output logic rc);
        @(negedge clk);
        req_valid  = 1'b1;
        req_data   = d;
        req_amount = a;
        req_type   = t;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (resp_valid !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        rd = resp_data;
        rc = resp_carry;
    endtask

    task automatic consume();
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (resp_data !== 32'h0) begin bad++; $display("FAIL reset_resp_data got=%h want=0", resp_data); end
        total++; if (resp_carry !== 1'b0) begin bad++; $display("FAIL reset_resp_carry got=%b want=0", resp_carry); end
        reset = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b want=1", req_ready); end
    endtask

    task automatic test_lsl();
        vec_t v[4];
        int lat;
        logic [31:0] rd;
        logic rc;
        v[0] = '{32'h00000001, 8'd5,  2'b00, 32'h00000020, 1'b0, 2};
        v[1] = '{32'h00000001, 8'd32, 2'b00, 32'h00000000, 1'b1, 8};
        v[2] = '{32'h00000003, 8'd33, 2'b00, 32'h00000000, 1'b0, 9};
        v[3] = '{32'h80000001, 8'd1,  2'b00, 32'h00000002, 1'b1, 1};
        for (int i = 0; i < 4; i++) begin
            issue(v[i].d, v[i].a, v[i].t, lat, rd, rc);
            total++; if (rd !== v[i].exp) begin bad++; $display("FAIL lsl_data[%0d] got=%h want=%h", i, rd, v[i].exp); end
            total++; if (rc !== v[i].c) begin bad++; $display("FAIL lsl_carry[%0d] got=%b want=%b", i, rc, v[i].c); end
            total++; if (lat != v[i].lat) begin bad++; $display("FAIL lsl_latency[%0d] got=%0d want=%0d", i, lat, v[i].lat); end
            consume();
            total++; if (req_ready !== 1'b1 || resp_data !== 32'h0) begin bad++; $display("FAIL lsl_release[%0d] got ready=%b data=%h want ready=1 data=0", i, req_ready, resp_data); end
        end
    endtask

    task automatic test_lsr();
        vec_t v[5];
        int lat;
        logic [31:0] rd;
        logic rc;
        v[0] = '{32'h80000000, 8'd32,  2'b01, 32'h00000000, 1'b1, 8};
        v[1] = '{32'h80000000, 8'd40,  2'b01, 32'h00000000, 1'b0, 9};
        v[2] = '{32'h000000F8, 8'd4,   2'b01, 32'h0000000F, 1'b1, 1};
        v[3] = '{32'hFFFFFFFF, 8'd200, 2'b01, 32'h00000000, 1'b0, 9};
        v[4] = '{32'h00000006, 8'd2,   2'b01, 32'h00000001, 1'b1, 1};
        for (int i = 0; i < 5; i++) begin
            issue(v[i].d, v[i].a, v[i].t, lat, rd, rc);
            total++; if (rd !== v[i].exp) begin bad++; $display("FAIL lsr_data[%0d] got=%h want=%h", i, rd, v[i].exp); end
            total++; if (rc !== v[i].c) begin bad++; $display("FAIL lsr_carry[%0d] got=%b want=%b", i, rc, v[i].c); end
            total++; if (lat != v[i].lat) begin bad++; $display("FAIL lsr_latency[%0d] got=%0d want=%0d", i, lat, v[i].lat); end
            consume();
        end
    endtask

    task automatic test_asr();
        vec_t v[4];
        int lat;
        logic [31:0] rd;
        logic rc;
        v[0] = '{32'h800000F0, 8'd4,   2'b10, 32'hF800000F, 1'b0, 1};
        v[1] = '{32'h800000F0, 8'd255, 2'b10, 32'hFFFFFFFF, 1'b1, 8};
        v[2] = '{32'h7FFFFFFF, 8'd31,  2'b10, 32'h00000000, 1'b1, 8};
        v[3] = '{32'h7FFFFFFF, 8'd40,  2'b10, 32'h00000000, 1'b0, 8};
        for (int i = 0; i < 4; i++) begin
            issue(v[i].d, v[i].a, v[i].t, lat, rd, rc);
            total++; if (rd !== v[i].exp) begin bad++; $display("FAIL asr_data[%0d] got=%h want=%h", i, rd, v[i].exp); end
            total++; if (rc !== v[i].c) begin bad++; $display("FAIL asr_carry[%0d] got=%b want=%b", i, rc, v[i].c); end
            total++; if (lat != v[i].lat) begin bad++; $display("FAIL asr_latency[%0d] got=%0d want=%0d", i, lat, v[i].lat); end
            consume();
        end
    endtask

    task automatic test_ror();
        vec_t v[4];
        int lat;
        logic [31:0] rd;
        logic rc;
        v[0] = '{32'h00000001, 8'd1,  2'b11, 32'h80000000, 1'b1, 1};
        v[1] = '{32'h12345678, 8'd4,  2'b11, 32'h81234567, 1'b1, 1};
        v[2] = '{32'h12345678, 8'd36, 2'b11, 32'h81234567, 1'b1, 1};
        v[3] = '{32'h00000100, 8'd9,  2'b11, 32'h80000000, 1'b1, 3};
        for (int i = 0; i < 4; i++) begin
            issue(v[i].d, v[i].a, v[i].t, lat, rd, rc);
            total++; if (rd !== v[i].exp) begin bad++; $display("FAIL ror_data[%0d] got=%h want=%h", i, rd, v[i].exp); end
            total++; if (rc !== v[i].c) begin bad++; $display("FAIL ror_carry[%0d] got=%b want=%b", i, rc, v[i].c); end
            total++; if (lat != v[i].lat) begin bad++; $display("FAIL ror_latency[%0d] got=%0d want=%0d", i, lat, v[i].lat); end
            consume();
        end
    endtask

    task automatic test_zero_amount();
        vec_t v[4];
        int lat;
        logic [31:0] rd;
        logic rc;
        v[0] = '{32'h00001234, 8'd0,  2'b00, 32'h00001234, 1'b0, -1};
        v[1] = '{32'h80000000, 8'd0,  2'b10, 32'h80000000, 1'b0, -1};
        v[2] = '{32'h00000001, 8'd32, 2'b11, 32'h00000001, 1'b0, -1};
        v[3] = '{32'h80000001, 8'd64, 2'b11, 32'h80000001, 1'b1, -1};
        for (int i = 0; i < 4; i++) begin
            issue(v[i].d, v[i].a, v[i].t, lat, rd, rc);
            total++; if (rd !== v[i].exp) begin bad++; $display("FAIL zero_data[%0d] got=%h want=%h", i, rd, v[i].exp); end
            total++; if (rc !== v[i].c) begin bad++; $display("FAIL zero_carry[%0d] got=%b want=%b", i, rc, v[i].c); end
            total++; if (lat > 1) begin bad++; $display("FAIL zero_latency[%0d] got=%0d want<=1", i, lat); end
            consume();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [31:0] rd;
        logic rc;
        issue(32'h000000F8, 8'd4, 2'b01, lat, rd, rc);
        total++; if (rd !== 32'h0000000F || rc !== 1'b1) begin bad++; $display("FAIL bp_first got=%h/%b want=0000000f/1", rd, rc); end
        req_valid  = 1'b1;
        req_data   = 32'hDEADBEEF;
        req_amount = 8'd1;
        req_type   = 2'b00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (resp_data !== 32'h0000000F || resp_carry !== 1'b1) begin bad++; $display("FAIL bp_hold[%0d] got=%h/%b want=0000000f/1", k, resp_data, resp_carry); end
            total++; if (req_ready !== 1'b0 || resp_valid !== 1'b1) begin bad++; $display("FAIL bp_ready[%0d] got ready=%b valid=%b want 0/1", k, req_ready, resp_valid); end
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        total++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 32'h0) begin bad++; $display("FAIL bp_idle got ready=%b valid=%b data=%h want 1/0/0", req_ready, resp_valid, resp_data); end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b1 || resp_valid !== 1'b0) begin bad++; $display("FAIL bp_second_shift got busy=%b valid=%b want 1/0", busy, resp_valid); end
        @(negedge clk);
        total++; if (resp_valid !== 1'b1 || resp_data !== 32'hBD5B7DDE || resp_carry !== 1'b1) begin bad++; $display("FAIL bp_second got valid=%b data=%h carry=%b want 1/bd5b7dde/1", resp_valid, resp_data, resp_carry); end
        consume();
    endtask

    task automatic test_reset_abort();
        int lat;
        int seen;
        logic [31:0] rd;
        logic rc;
        @(negedge clk);
        req_valid  = 1'b1;
        req_data   = 32'h00000001;
        req_amount = 8'd20;
        req_type   = 2'b00;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy_before got=%b want=1", busy); end
        reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin bad++; $display("FAIL abort_state got busy=%b valid=%b want 0/0", busy, resp_valid); end
        total++; if (req_ready !== 1'b1 || resp_data !== 32'h0) begin bad++; $display("FAIL abort_idle got ready=%b data=%h want 1/0", req_ready, resp_data); end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL abort_no_resp got=%0d want=0", seen); end
        issue(32'h00000003, 8'd2, 2'b00, lat, rd, rc);
        total++; if (rd !== 32'h0000000C || rc !== 1'b0 || lat != 1) begin bad++; $display("FAIL abort_next got=%h/%b/%0d want=0000000c/0/1", rd, rc, lat); end
        consume();
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_data   = 32'h0;
        req_amount = 8'd0;
        req_type   = 2'b00;
        resp_ready = 1'b0;
        test_reset();
        test_lsl();
        test_lsr();
        test_asr();
        test_ror();
        test_zero_amount();
        test_backpressure();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
